// File: rtl/axi4s_width_pkg.sv
// -----------------------------------------------------------------------------
// axi4s_width_pkg
// Shared types and helpers for the AXI4-Stream width downsizer.
//   - axi4s_mask_t / axi4s_idx_t / axi4s_pos_t : chunk-mask and chunk-index
//     types sized for the largest supported width ratio (AXI4S_MAX_RATIO).
//     Narrower ratios zero-extend into them and truncate results back.
//   - axi4s_beat_t : buffered-beat layout for the family default 256->64
//     geometry; the parametrised top keeps the same field order.
//   - chunk_mask_f, next_set_bit, highest_set_bit : chunk sequencing helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package axi4s_width_pkg;

  localparam int AXI4S_MAX_RATIO = 64;
  localparam int AXI4S_IDX_W     = 6;

  localparam int AXI4S_DEF_SRC_W      = 256;
  localparam int AXI4S_DEF_DST_W      = 64;
  localparam int AXI4S_DEF_RATIO      = AXI4S_DEF_SRC_W / AXI4S_DEF_DST_W;
  localparam int AXI4S_DEF_ID_W       = 4;
  localparam int AXI4S_DEF_DEST_W     = 4;
  localparam int AXI4S_DEF_DST_USER_W = 4;

  typedef logic [AXI4S_MAX_RATIO-1:0] axi4s_mask_t;
  typedef logic [AXI4S_IDX_W-1:0]     axi4s_idx_t;
  // One bit wider than an index so "index + 1" past the top chunk is representable.
  typedef logic [AXI4S_IDX_W:0]       axi4s_pos_t;

  typedef struct packed {
    logic [AXI4S_DEF_RATIO-1:0]      mask;
    logic [AXI4S_DEF_ID_W-1:0]       id;
    logic [AXI4S_DEF_DEST_W-1:0]     dest;
    logic [AXI4S_DEF_DST_USER_W-1:0] user;
    logic                            last;
    logic [AXI4S_DEF_SRC_W/8-1:0]    strb;
    logic [AXI4S_DEF_SRC_W/8-1:0]    keep;
    logic [AXI4S_DEF_SRC_W-1:0]      data;
  } axi4s_beat_t;

  // Highest set bit of mask; 0 when the mask is empty.
  function automatic axi4s_idx_t highest_set_bit(input axi4s_mask_t mask);
    axi4s_idx_t h;
    h = '0;
    for (int i = 0; i < AXI4S_MAX_RATIO; i++) begin
      if (mask[i]) begin
        h = axi4s_idx_t'(i);
      end else begin
        h = h;
      end
    end
    return h;
  endfunction

  // Lowest set bit at or above 'from'; 0 when there is none.
  function automatic axi4s_idx_t next_set_bit(input axi4s_mask_t mask, input axi4s_pos_t from);
    axi4s_idx_t r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < AXI4S_MAX_RATIO; i++) begin
      if (!found && (i >= int'(from)) && mask[i]) begin
        r     = axi4s_idx_t'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return r;
  endfunction

  // Chunk mask of a beat from its per-chunk "keep slice nonzero" flags.
  // Dense mode: non-last beats emit every chunk, last beats emit 0..highest
  // nonzero chunk. Sparse mode: only nonzero chunks. Either way a last beat
  // always emits at least chunk 0 so TLAST is never lost; an all-zero mask
  // (sparse, non-last) means the beat is dropped.
  function automatic axi4s_mask_t chunk_mask_f(input axi4s_mask_t nz, input logic last,
                                               input logic sparse, input int ratio);
    axi4s_mask_t full_m;
    axi4s_mask_t m;
    axi4s_idx_t  h;
    full_m = '0;
    m      = '0;
    for (int i = 0; i < AXI4S_MAX_RATIO; i++) begin
      if (i < ratio) begin
        full_m[i] = 1'b1;
      end else begin
        full_m[i] = 1'b0;
      end
    end
    h = highest_set_bit(nz & full_m);
    if (sparse) begin
      m = nz & full_m;
    end else if (!last) begin
      m = full_m;
    end else begin
      for (int i = 0; i < AXI4S_MAX_RATIO; i++) begin
        m[i] = (i <= int'(h));
      end
    end
    if (last && (m == '0)) begin
      m[0] = 1'b1;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// -----------------------------------------------------------------------------
// axi4_stream_if
// AXI4-Stream bundle. Parameters: DATA_WIDTH (multiple of 8), ID_WIDTH,
// DEST_WIDTH, USER_WIDTH.
//   modport src : drives tvalid/tdata/tkeep/tstrb/tlast/tid/tdest/tuser, samples tready.
//   modport dst : samples the payload, drives tready.
// -----------------------------------------------------------------------------
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport src (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
  modport dst (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axi4s_beat_fifo2.sv
// -----------------------------------------------------------------------------
// axi4s_beat_fifo2
// Generic two-entry FIFO. Entry 0 is always the head, entry 1 the next entry.
// Ports:
//   clk_i, rst_ni     : clock, async active-low reset
//   push_i, push_data_i : write request (ignored when full)
//   pop_i             : remove head (ignored when empty)
//   count_o           : occupancy 0..2
//   head_o, next_o    : entry 0 / entry 1 contents
// -----------------------------------------------------------------------------
module axi4s_beat_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] mem0_q, mem0_d;
  logic [WIDTH-1:0] mem1_q, mem1_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Next-state of storage and occupancy for push/pop combinations
  always_comb begin
    mem0_d    = mem0_q;
    mem1_d    = mem1_q;
    count_d   = count_q;
    push_ok_s = push_i && (count_q != 2'd2);
    pop_ok_s  = pop_i && (count_q != 2'd0);
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        if (count_q == 2'd0) begin
          mem0_d = push_data_i;
        end else begin
          mem1_d = push_data_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      // Push only succeeds below 2 entries, so here count is 1: replace head.
      2'b11: begin
        mem0_d  = push_data_i;
        count_d = count_q;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Storage and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem0_q;
  assign next_o  = mem1_q;

endmodule

// File: rtl/axi4s_width_downsizer.sv
// -----------------------------------------------------------------------------
// axi4s_width_downsizer
// Splits each wide AXI4-Stream beat into RATIO = SRC/DST narrow chunks, LSB
// chunk first, through a two-entry beat buffer (no combinational path from
// axis_out.tready to axis_in.tready). Trailing null chunks of a last beat are
// trimmed; TID/TDEST repeat on every chunk; TUSER is truncated or zero-extended.
// Optional feature macro: AXI4S_DOWNSIZER_SPARSE_SKIP_EN -- skip every chunk
// whose keep slice is zero and drop all-zero-keep non-last beats.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : async active-low reset
//   axis_in  : wide input stream  (axi4_stream_if.dst, SRC_DATA_WIDTH)
//   axis_out : narrow output stream (axi4_stream_if.src, DST_DATA_WIDTH)
// -----------------------------------------------------------------------------
module axi4s_width_downsizer
  import axi4s_width_pkg::*;
#(
  parameter int SRC_DATA_WIDTH = 256,
  parameter int DST_DATA_WIDTH = 64,
  parameter int ID_WIDTH       = 4,
  parameter int DEST_WIDTH     = 4,
  parameter int SRC_USER_WIDTH = 16,
  parameter int DST_USER_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  axi4_stream_if.dst axis_in,
  axi4_stream_if.src axis_out
);

  localparam int RATIO     = SRC_DATA_WIDTH / DST_DATA_WIDTH;
  localparam int SRC_BYTES = SRC_DATA_WIDTH / 8;
  localparam int DST_BYTES = DST_DATA_WIDTH / 8;
  localparam int CIDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

`ifdef AXI4S_DOWNSIZER_SPARSE_SKIP_EN
  localparam logic SPARSE_EN = 1'b1;
`else
  localparam logic SPARSE_EN = 1'b0;
`endif

  if (((SRC_DATA_WIDTH % DST_DATA_WIDTH) != 0) || ((DST_DATA_WIDTH % 8) != 0)) begin : g_bad_width
    $error("axi4s_width_downsizer: SRC_DATA_WIDTH must be a multiple of DST_DATA_WIDTH, both multiples of 8");
  end
  if (RATIO > AXI4S_MAX_RATIO) begin : g_bad_ratio
    $error("axi4s_width_downsizer: width ratio exceeds AXI4S_MAX_RATIO");
  end

  typedef struct packed {
    logic [RATIO-1:0]          mask;
    logic [ID_WIDTH-1:0]       id;
    logic [DEST_WIDTH-1:0]     dest;
    logic [DST_USER_WIDTH-1:0] user;
    logic                      last;
    logic [SRC_BYTES-1:0]      strb;
    logic [SRC_BYTES-1:0]      keep;
    logic [SRC_DATA_WIDTH-1:0] data;
  } beat_t;

  logic [RATIO-1:0]          in_nz_s;
  logic [RATIO-1:0]          in_mask_s;
  logic [DST_USER_WIDTH-1:0] in_user_s;
  beat_t                     in_beat_s;
  beat_t                     head_s;
  beat_t                     next_s;
  logic [1:0]                count_s;
  logic                      in_ready_s;
  logic                      in_fire_s;
  logic                      push_s;
  logic                      out_valid_s;
  logic                      out_fire_s;
  logic                      is_final_s;
  logic                      pop_s;
  logic [CIDX_W-1:0]         cur_q, cur_d;

  logic [DST_DATA_WIDTH-1:0] out_data_s;
  logic [DST_BYTES-1:0]      out_keep_s;
  logic [DST_BYTES-1:0]      out_strb_s;
  logic                      out_last_s;
  logic [ID_WIDTH-1:0]       out_id_s;
  logic [DEST_WIDTH-1:0]     out_dest_s;
  logic [DST_USER_WIDTH-1:0] out_user_s;

  // Per-chunk "keep slice has any byte" flags of the offered input beat.
  for (genvar c = 0; c < RATIO; c++) begin : g_nz
    assign in_nz_s[c] = |axis_in.tkeep[c*DST_BYTES +: DST_BYTES];
  end

  // TUSER is adapted at accept so only the narrow width is buffered.
  if (DST_USER_WIDTH <= SRC_USER_WIDTH) begin : g_user_trunc
    assign in_user_s = axis_in.tuser[DST_USER_WIDTH-1:0];
  end else begin : g_user_ext
    assign in_user_s = {{(DST_USER_WIDTH-SRC_USER_WIDTH){1'b0}}, axis_in.tuser};
  end

  assign in_ready_s     = (count_s != 2'd2);
  assign axis_in.tready = in_ready_s;
  assign in_fire_s      = axis_in.tvalid && in_ready_s;
  // An empty mask only arises for a sparse-mode all-null non-last beat: accept, don't store.
  assign push_s         = in_fire_s && (in_mask_s != '0);

  // Chunk mask and buffered entry for the offered input beat
  always_comb begin
    in_mask_s      = RATIO'(chunk_mask_f(axi4s_mask_t'(in_nz_s), axis_in.tlast, SPARSE_EN, RATIO));
    in_beat_s      = '0;
    in_beat_s.mask = in_mask_s;
    in_beat_s.id   = axis_in.tid;
    in_beat_s.dest = axis_in.tdest;
    in_beat_s.user = in_user_s;
    in_beat_s.last = axis_in.tlast;
    in_beat_s.strb = axis_in.tstrb;
    in_beat_s.keep = axis_in.tkeep;
    in_beat_s.data = axis_in.tdata;
  end

  axi4s_beat_fifo2 #(
    .WIDTH ($bits(beat_t))
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (push_s),
    .push_data_i (in_beat_s),
    .pop_i       (pop_s),
    .count_o     (count_s),
    .head_o      (head_s),
    .next_o      (next_s)
  );

  assign out_valid_s = (count_s != 2'd0);
  assign out_fire_s  = out_valid_s && axis_out.tready;
  assign is_final_s  = (axi4s_idx_t'(cur_q) == highest_set_bit(axi4s_mask_t'(head_s.mask)));
  assign pop_s       = out_fire_s && is_final_s;

  // Chunk index sequencing: step to next mask bit, or jump to the first chunk of the new head
  always_comb begin
    cur_d = cur_q;
    if (out_fire_s && !is_final_s) begin
      cur_d = CIDX_W'(next_set_bit(axi4s_mask_t'(head_s.mask),
                                   axi4s_pos_t'(cur_q) + axi4s_pos_t'(1)));
    end else if (out_fire_s) begin
      if (count_s == 2'd2) begin
        cur_d = CIDX_W'(next_set_bit(axi4s_mask_t'(next_s.mask), axi4s_pos_t'(0)));
      end else if (push_s) begin
        cur_d = CIDX_W'(next_set_bit(axi4s_mask_t'(in_mask_s), axi4s_pos_t'(0)));
      end else begin
        cur_d = '0;
      end
    end else if ((count_s == 2'd0) && push_s) begin
      cur_d = CIDX_W'(next_set_bit(axi4s_mask_t'(in_mask_s), axi4s_pos_t'(0)));
    end else begin
      cur_d = cur_q;
    end
  end

  // Current chunk index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
    end else begin
      cur_q <= cur_d;
    end
  end

  // Output slice mux; payload forced to zero whenever no chunk is offered
  always_comb begin
    out_data_s = '0;
    out_keep_s = '0;
    out_strb_s = '0;
    out_last_s = 1'b0;
    out_id_s   = '0;
    out_dest_s = '0;
    out_user_s = '0;
    if (out_valid_s) begin
      out_data_s = head_s.data[cur_q*DST_DATA_WIDTH +: DST_DATA_WIDTH];
      out_keep_s = head_s.keep[cur_q*DST_BYTES +: DST_BYTES];
      out_strb_s = head_s.strb[cur_q*DST_BYTES +: DST_BYTES];
      out_last_s = head_s.last && is_final_s;
      out_id_s   = head_s.id;
      out_dest_s = head_s.dest;
      out_user_s = head_s.user;
    end else begin
      out_last_s = 1'b0;
    end
  end

  assign axis_out.tvalid = out_valid_s;
  assign axis_out.tdata  = out_data_s;
  assign axis_out.tkeep  = out_keep_s;
  assign axis_out.tstrb  = out_strb_s;
  assign axis_out.tlast  = out_last_s;
  assign axis_out.tid    = out_id_s;
  assign axis_out.tdest  = out_dest_s;
  assign axis_out.tuser  = out_user_s;

endmodule

// File: tb/tb_axi4s_width_downsizer.sv
// -----------------------------------------------------------------------------
// tb_axi4s_width_downsizer
// Directed + randomized bench for the 256->64 downsizer. A chunk-list model
// (per accepted beat: which 64-bit slices come out, in order) predicts every
// output chunk; a monitor on the falling edge compares, checks stall
// stability, idle-zero payload and input ready vs. buffered-beat count.
// -----------------------------------------------------------------------------
module tb_axi4s_width_downsizer;

`ifdef AXI4S_DOWNSIZER_SPARSE_SKIP_EN
  localparam bit SPARSE = 1'b1;
`else
  localparam bit SPARSE = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  strb;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [3:0]  user;
    bit          beat_end;
  } chunk_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  axi4_stream_if #(.DATA_WIDTH(256), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(16)) in_if ();
  axi4_stream_if #(.DATA_WIDTH(64),  .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4))  out_if ();

  axi4s_width_downsizer #(
    .SRC_DATA_WIDTH (256),
    .DST_DATA_WIDTH (64),
    .ID_WIDTH       (4),
    .DEST_WIDTH     (4),
    .SRC_USER_WIDTH (16),
    .DST_USER_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .axis_in  (in_if),
    .axis_out (out_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int     tests = 0;
  int     fails = 0;
  chunk_t exp_q[$];
  int     outstanding = 0;
  int     n_chunks, n_tlast, first_acc_cyc, first_out_cyc, last_out_cyc;
  int     beats_in, beats_done;
  bit     rnd_rdy = 1'b0;
  bit     prev_valid = 1'b0;
  bit     prev_ready = 1'b0;
  logic [92:0] prev_bundle;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_chunks = 0; n_tlast = 0; first_acc_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    beats_in = 0; beats_done = 0;
  endtask

  // Reference: list the 64-bit slices a 256-bit beat produces, from the keep rules.
  function automatic void model_accept(input logic [255:0] d, input logic [31:0] k,
                                       input logic [31:0] s, input logic l, input logic [3:0] id,
                                       input logic [3:0] dest, input logic [15:0] u);
    int sel[$];
    int hi = 0;
    bit nz[4];
    for (int c = 0; c < 4; c++) begin
      nz[c] = (k[c*8 +: 8] != 8'h00);
      if (nz[c]) hi = c;
    end
    if (SPARSE) begin
      for (int c = 0; c < 4; c++) if (nz[c]) sel.push_back(c);
      if (sel.size() == 0 && l) sel.push_back(0);
    end else if (!l) begin
      for (int c = 0; c < 4; c++) sel.push_back(c);
    end else begin
      for (int c = 0; c <= hi; c++) sel.push_back(c);
    end
    if (sel.size() == 0) return;
    outstanding++;
    beats_in++;
    foreach (sel[j]) begin
      chunk_t e;
      e.data = d[sel[j]*64 +: 64];
      e.keep = k[sel[j]*8 +: 8];
      e.strb = s[sel[j]*8 +: 8];
      e.beat_end = (j == sel.size() - 1);
      e.last = l && e.beat_end;
      e.id = id; e.dest = dest; e.user = u[3:0];
      exp_q.push_back(e);
    end
  endfunction

  // Output monitor / scoreboard, sampled away from the active edge
  always @(negedge clk) begin
    logic [92:0] bundle;
    bundle = {out_if.tdata, out_if.tkeep, out_if.tstrb, out_if.tlast,
              out_if.tid, out_if.tdest, out_if.tuser};
    if (rst_n === 1'b1) begin
      chk("in_tready", in_if.tready, (outstanding != 2));
      if (prev_valid && !prev_ready) begin
        chk("stall_hold", {out_if.tvalid, bundle}, {1'b1, prev_bundle});
      end
      if (!out_if.tvalid) begin
        chk("idle_zero", bundle, 0);
      end else if (out_if.tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_chunk", bundle, 0);
        end else begin
          chunk_t e;
          e = exp_q.pop_front();
          chk("chunk", bundle, {e.data, e.keep, e.strb, e.last, e.id, e.dest, e.user});
          if (e.beat_end) begin outstanding--; beats_done++; end
        end
        n_chunks++;
        if (out_if.tlast) n_tlast++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      if (in_if.tvalid && in_if.tready) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        model_accept(in_if.tdata, in_if.tkeep, in_if.tstrb, in_if.tlast,
                     in_if.tid, in_if.tdest, in_if.tuser);
      end
      prev_valid = out_if.tvalid;
      prev_ready = out_if.tready;
      prev_bundle = bundle;
    end
  end

  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic [31:0] s,
                           input logic l, input logic [3:0] id, input logic [3:0] dest,
                           input logic [15:0] u);
    bit ok = 1'b0;
    in_if.tdata = d; in_if.tkeep = k; in_if.tstrb = s; in_if.tlast = l;
    in_if.tid = id; in_if.tdest = dest; in_if.tuser = u; in_if.tvalid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_if.tready) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk); #1;
    in_if.tvalid = 1'b0;
    in_if.tlast = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !out_if.tvalid) begin done = 1'b1; break; end
    end
    chk("drain", done, 1);
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [31:0] k;
    fork
      forever begin
        @(posedge clk); #1;
        if (rnd_rdy) out_if.tready = 1'($urandom_range(0, 1));
      end
    join_none

    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = '0; in_if.tstrb = '0;
    in_if.tlast = 1'b0; in_if.tid = '0; in_if.tdest = '0; in_if.tuser = '0;
    out_if.tready = 1'b0;
    clr_stats();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tvalid", out_if.tvalid, 0);
    chk("rst_tdata", out_if.tdata, 0);
    chk("rst_tlast", out_if.tlast, 0);
    chk("rst_in_tready", in_if.tready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_tvalid", out_if.tvalid, 0);
    chk("post_rst_in_tready", in_if.tready, 1);

    // Three full beats, no backpressure: 12 gap-free chunks, latency 1
    out_if.tready = 1'b1;
    clr_stats();
    send_beat(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h3, 4'h5, 16'hABCD);
    send_beat(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h3, 4'h5, 16'hABCD);
    send_beat(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h3, 4'h5, 16'hABCD);
    wait_drain();
    chk("full_pkt_chunks", n_chunks, 12);
    chk("full_pkt_tlast", n_tlast, 1);
    chk("first_latency", first_out_cyc - first_acc_cyc, 1);
    chk("gap_free_span", last_out_cyc - first_out_cyc, 11);

    // Last beat with 16 bytes kept: two chunks only
    clr_stats();
    send_beat(rnd256(), 32'h0000_FFFF, 32'h0000_F0FF, 1'b1, 4'h1, 4'h2, 16'h0007);
    wait_drain();
    chk("trim16_chunks", n_chunks, 2);
    chk("trim16_tlast", n_tlast, 1);

    // Last beat with no bytes kept: single null chunk with TLAST
    clr_stats();
    send_beat(rnd256(), 32'h0000_0000, 32'h0000_0000, 1'b1, 4'h9, 4'hA, 16'h1234);
    wait_drain();
    chk("null_last_chunks", n_chunks, 1);
    chk("null_last_tlast", n_tlast, 1);

`ifdef AXI4S_DOWNSIZER_SPARSE_SKIP_EN
    clr_stats();
    send_beat(rnd256(), 32'hFF00_00FF, 32'hFF00_00FF, 1'b0, 4'h2, 4'h2, 16'h0002);
    send_beat(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h2, 4'h2, 16'h0002);
    wait_drain();
    chk("sparse_skip_chunks", n_chunks, 6);
    clr_stats();
    send_beat(rnd256(), 32'h0000_0000, 32'h0000_0000, 1'b0, 4'h4, 4'h4, 16'h0004);
    send_beat(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h4, 4'h4, 16'h0004);
    wait_drain();
    chk("sparse_drop_chunks", n_chunks, 4);
    chk("sparse_drop_beats", beats_in, 1);
`endif

    // 100 random beats under random backpressure
    clr_stats();
    rnd_rdy = 1'b1;
    for (int b = 0; b < 100; b++) begin
      logic lst;
      lst = ($urandom_range(0, 3) == 0) || (b == 99);
      if (!lst) begin
        k = 32'hFFFF_FFFF;
      end else if ($urandom_range(0, 3) == 0) begin
        k = 32'h0;
      end else begin
        k = 32'hFFFF_FFFF >> $urandom_range(0, 31);
      end
      send_beat(rnd256(), k, $urandom & k, lst, 4'($urandom), 4'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    wait_drain();
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    out_if.tready = 1'b1;
    chk("rand_beats_in", beats_in, 100);
    chk("rand_beats_done", beats_done, 100);

    // Reset with two beats buffered
    out_if.tready = 1'b0;
    send_beat(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h6, 4'h6, 16'h0006);
    send_beat(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h6, 4'h6, 16'h0006);
    #1;
    chk("full_in_tready", in_if.tready, 0);
    chk("full_tvalid", out_if.tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", out_if.tvalid, 0);
    chk("async_rst_in_tready", in_if.tready, 1);
    exp_q.delete();
    outstanding = 0;
    prev_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_if.tready = 1'b1;
    clr_stats();
    send_beat(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h8, 4'h8, 16'h0008);
    wait_drain();
    chk("fresh_pkt_chunks", n_chunks, 4);
    chk("fresh_pkt_tlast", n_tlast, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
